aes_block_packer: RTL and testbench
===================================

// Module: aes_block_packer
// PURPOSE
//  Upstream feeder for aes256_fifo. Packs a 32-bit word stream into 128-bit AES blocks on aes_in_*.
//  Zero-pads a trailing partial block and flags the message end.
//  One block of skid buffering, so accumulation of block N+1 overlaps the hand-off of block N.
// PARAMETERS
//  WORD_W      32   input word width; BLOCK_W must be a multiple of it
//  BLOCK_W     128  output block width (AES block)
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        asynchronous active-low reset
//  clear          in   1        sync flush: drop partial and held block
//  s_valid        in   1        input word valid
//  s_ready        out  1        packer can accept a word
//  s_data         in   WORD_W   input word
//  s_last         in   1        this word ends the message
//  aes_in_valid   out  1        block valid (to aes256_fifo)
//  aes_in_ready   in   1        aes256_fifo accepts block
//  aes_in_block   out  BLOCK_W  packed block
//  aes_in_last    out  1        block is final block of message
//  aes_in_nwords  out  3        meaningful words in block, 1..4
// BEHAVIOUR
//  Handshakes
//   - Word accepted on a rising clk when s_valid && s_ready.
//   - Block accepted on a rising clk when aes_in_valid && aes_in_ready.
//   - Valid never depends on ready.
//   - aes_in_block, aes_in_last and aes_in_nwords stay stable while aes_in_valid && !aes_in_ready.
//  Reset (rst_n low, async)
//   - aes_in_valid=0, aes_in_block=0, aes_in_last=0, aes_in_nwords=0.
//   - Word index=0, accumulator=0, acc_full=0, s_ready=1.
//   - Reset mid-block discards everything; no partial output is produced.
//  Packing
//   - Word k of a block (k=0..3) lands in bits [BLOCK_W-1-32k -: 32]; the first word is the MS word.
//   - 2-bit word index increments per accepted word.
//   - Index wraps 3->0 on block completion, or 0 after s_last.
//  Block completion
//   - Occurs on accept of word index 3, or on any accept with s_last=1.
//   - Unfilled words are 0.
//   - nwords = index+1; last = s_last.
//  Hand-off
//   - Condition: aes_in_valid==0, or aes_in_ready is high on the same edge.
//   - If met, the completed block loads the output register on the completing edge.
//   - aes_in_valid rises the next cycle (1-cycle latency from the 4th word).
//   - Otherwise the block is held in the accumulator, acc_full=1, s_ready=0.
//   - The held block moves to the output on the edge where the current block is accepted.
//   - Then acc_full=0 and s_ready=1 the following cycle.
//  s_ready
//   - s_ready = !acc_full (registered; no combinational path from aes_in_ready).
//  Throughput
//   - With aes_in_ready held 1: 1 word/cycle sustained, 1 block per 4 cycles.
//  clear (sync)
//   - Has priority over accepts on the same edge.
//   - Next cycle: aes_in_valid=0, index=0, acc_full=0, accumulator zeroed.
//  Boundary cases
//   - s_last on the first word: nwords=1, three zero words.
//   - s_last on word 3: nwords=4, last=1.
//   - Back-to-back messages: the next word after s_last starts a fresh block at index 0.
//   - Completion and output acceptance on the same edge: new block replaces old; valid stays 1; no bubble.
// STRUCTURE
//  - Shared package aes_stream_pkg: AES_BLOCK_W=128, AES_WORD_W=32, WORDS_PER_BLOCK=4, NWORDS_W=3.
//  - aes256_fifo and its downstream unpacker import the same package.
//  - Single module; no sub-module.
//  - State: index, accumulator, acc_full, output register.
// TESTING
//  1. Words 0x00000001..0x00000004, s_last on 4th, aes_in_ready=1
//     -> one block 0x00000001_00000002_00000003_00000004, nwords=4, last=1; valid 1 cycle after the 4th accept.
//  2. Single word 0xDEADBEEF with s_last
//     -> block 0xDEADBEEF_00000000_00000000_00000000, nwords=1, last=1.
//  3. 12 words streamed, aes_in_ready=0 until cycle 20
//     -> s_ready drops after word 8; blocks emerge in order with no loss after ready rises; s_ready returns.
//  4. 16 words back-to-back, aes_in_ready=1
//     -> 4 blocks on consecutive 4-cycle slots; s_ready never low.
//  5. clear after 2 words of a block, then 4 new words
//     -> only the new block is emitted; index restarted at 0.
//  6. rst_n pulsed low mid-block, held output unaccepted
//     -> aes_in_valid=0 immediately (async); post-reset block contains only post-reset words.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared widths for the AES block stream: packer, aes256_fifo and the
// downstream unpacker all import this package.
`timescale 1ns/1ps
package aes_stream_pkg;
   localparam int AES_BLOCK_W     = 128;
   localparam int AES_WORD_W      = 32;
   localparam int WORDS_PER_BLOCK = AES_BLOCK_W / AES_WORD_W;
   localparam int NWORDS_W        = 3;
endpackage

// File: rtl/aes_block_packer.sv
// Packs a word stream into AES blocks, zero-pads a trailing partial block
// and holds one completed block while the output register is stalled.
`timescale 1ns/1ps
module aes_block_packer
   import aes_stream_pkg::*;
#(
   parameter int WORD_W  = AES_WORD_W,
   parameter int BLOCK_W = AES_BLOCK_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [WORD_W-1:0]  s_data,
   input  logic               s_last,
   output logic               aes_in_valid,
   input  logic               aes_in_ready,
   output logic [BLOCK_W-1:0] aes_in_block,
   output logic               aes_in_last,
   output logic [NWORDS_W-1:0] aes_in_nwords
);

   localparam int NW = BLOCK_W / WORD_W;
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;

   logic [IW-1:0]       r_idx;
   logic [BLOCK_W-1:0]  r_acc;
   logic                r_acc_full;
   logic                r_acc_last;
   logic [NWORDS_W-1:0] r_acc_nw;
   logic                r_out_valid;
   logic [BLOCK_W-1:0]  r_out_block;
   logic                r_out_last;
   logic [NWORDS_W-1:0] r_out_nw;

   logic                w_word_fire;
   logic                w_blk_fire;
   logic                w_out_free;
   logic                w_done;
   logic [NWORDS_W-1:0] w_nw;
   logic [BLOCK_W-1:0]  w_acc_next;

   assign w_word_fire = s_valid && !r_acc_full;
   assign w_blk_fire  = r_out_valid && aes_in_ready;
   assign w_out_free  = !r_out_valid || aes_in_ready;
   assign w_done      = w_word_fire &&
                        (s_last || r_idx == IW'(NW - 1));
   assign w_nw        = NWORDS_W'(r_idx) + NWORDS_W'(1);

   // First word of a block is the most significant one.
   always_comb begin
      w_acc_next = r_acc;
      for (int k = 0; k < NW; k++) begin
         if (r_idx == IW'(k))
            w_acc_next[BLOCK_W-1-WORD_W*k -: WORD_W] = s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_acc      <= '0;
         r_acc_full <= 1'b0;
         r_acc_last <= 1'b0;
         r_acc_nw   <= '0;
      end else if (clear) begin
         r_idx      <= '0;
         r_acc      <= '0;
         r_acc_full <= 1'b0;
         r_acc_last <= 1'b0;
         r_acc_nw   <= '0;
      end else if (r_acc_full) begin
         if (w_blk_fire) begin
            r_acc      <= '0;
            r_acc_full <= 1'b0;
            r_acc_last <= 1'b0;
            r_acc_nw   <= '0;
         end
      end else if (w_word_fire) begin
         if (w_done) begin
            r_idx <= '0;
            if (w_out_free) begin
               r_acc <= '0;
            end else begin
               r_acc      <= w_acc_next;
               r_acc_full <= 1'b1;
               r_acc_last <= s_last;
               r_acc_nw   <= w_nw;
            end
         end else begin
            r_idx <= r_idx + IW'(1);
            r_acc <= w_acc_next;
         end
      end
   end

   // A held block is only ever released by acceptance of the current one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_block <= '0;
         r_out_last  <= 1'b0;
         r_out_nw    <= '0;
      end else if (clear) begin
         r_out_valid <= 1'b0;
         r_out_block <= '0;
         r_out_last  <= 1'b0;
         r_out_nw    <= '0;
      end else if (r_acc_full && w_blk_fire) begin
         r_out_block <= r_acc;
         r_out_last  <= r_acc_last;
         r_out_nw    <= r_acc_nw;
      end else if (w_done && w_out_free) begin
         r_out_valid <= 1'b1;
         r_out_block <= w_acc_next;
         r_out_last  <= s_last;
         r_out_nw    <= w_nw;
      end else if (w_blk_fire) begin
         r_out_valid <= 1'b0;
      end
   end

   assign s_ready       = !r_acc_full;
   assign aes_in_valid  = r_out_valid;
   assign aes_in_block  = r_out_block;
   assign aes_in_last   = r_out_last;
   assign aes_in_nwords = r_out_nw;

endmodule

// File: tb/tb_aes_block_packer.sv
// Randomized bench for aes_block_packer: words are chunked into expected
// blocks by a queue model and compared with the blocks the DUT hands off.
`timescale 1ns/1ps
module tb_aes_block_packer;
   import aes_stream_pkg::*;

   typedef struct packed {
      logic [127:0] b;
      logic         last;
      logic [2:0]   nw;
   } blk_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clear = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = '0;
   logic         s_last = 1'b0;
   logic         aes_in_valid;
   logic         aes_in_ready = 1'b0;
   logic [127:0] aes_in_block;
   logic         aes_in_last;
   logic [2:0]   aes_in_nwords;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ready_mode = 2;
   int acc_total = 0;
   int low_cnt = 0;
   int first_low = -1;
   logic [31:0] wq[$];
   bit          lq[$];
   blk_t        exp_q[$];
   blk_t        got_q[$];
   int          got_cyc[$];
   blk_t        held;
   bit          p_stall = 0;

   aes_block_packer dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last),
      .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready),
      .aes_in_block(aes_in_block), .aes_in_last(aes_in_last),
      .aes_in_nwords(aes_in_nwords)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       aes_in_ready = 1'b1;
            1:       aes_in_ready = 1'($urandom_range(1));
            default: aes_in_ready = 1'b0;
         endcase
      end
   end

   // Collects accepted blocks; a stalled block must not change.
   always @(negedge clk) begin
      if (!rst_n) begin
         p_stall = 0;
      end else begin
         if (p_stall) begin
            checks++;
            if ({aes_in_valid, aes_in_block, aes_in_last, aes_in_nwords}
                !== {1'b1, held}) begin
               errors++;
               $display("FAIL stall_stable got v=%0b %h/%0b/%0d want %h/%0b/%0d",
                        aes_in_valid, aes_in_block, aes_in_last,
                        aes_in_nwords, held.b, held.last, held.nw);
            end
         end
         if (aes_in_valid && aes_in_ready && !clear) begin
            got_q.push_back('{aes_in_block, aes_in_last, aes_in_nwords});
            got_cyc.push_back(cyc);
         end
         p_stall = aes_in_valid && !aes_in_ready && !clear;
         held = '{aes_in_block, aes_in_last, aes_in_nwords};
      end
   end

   // Message -> blocks: groups of four words, MS word first, zero padded.
   task automatic queue_msg(input int n, input bit with_last,
                            input bit model, input bit seq,
                            input logic [31:0] base);
      logic [31:0] w[$];
      blk_t e;
      int k;
      for (int i = 0; i < n; i++) begin
         w.push_back(seq ? base + 32'(i) : $urandom);
         wq.push_back(w[i]);
         lq.push_back(with_last && i == n - 1);
      end
      if (model) begin
         for (int b = 0; b < n; b += 4) begin
            k = (n - b < 4) ? n - b : 4;
            if (k < 4 && !with_last) break;
            e.b = '0;
            for (int j = 0; j < k; j++)
               e.b = e.b | ({w[b+j], 96'b0} >> (32 * j));
            e.nw = 3'(k);
            e.last = with_last && (b + k == n);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic send(input int gap_pct, input int budget);
      int n = 0;
      @(posedge clk);
      #1;
      while (wq.size() > 0 && n < budget) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data = wq[0];
            s_last = lq[0];
         end
         @(negedge clk);
         if (!s_ready) begin
            low_cnt++;
            if (first_low < 0) first_low = acc_total;
         end
         if (s_valid && s_ready) begin
            void'(wq.pop_front());
            void'(lq.pop_front());
            acc_total++;
         end
         @(posedge clk);
         #1;
         n++;
      end
      s_valid = 1'b0;
      s_last = 1'b0;
      checks++;
      if (wq.size() != 0) begin
         errors++;
         $display("FAIL send_timeout left=%0d words want 0", wq.size());
         wq.delete();
         lq.delete();
      end
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (got_q.size() < exp_q.size() && k < budget) begin
         @(negedge clk);
         k++;
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic start();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
      acc_total = 0;
      low_cnt = 0;
      first_low = -1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 5;
      if (aes_in_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid got %0b want 0", aes_in_valid);
      end
      if (aes_in_block !== '0) begin
         errors++; $display("FAIL rst_block got %h want 0", aes_in_block);
      end
      if (aes_in_last !== 1'b0) begin
         errors++; $display("FAIL rst_last got %0b want 0", aes_in_last);
      end
      if (aes_in_nwords !== 3'd0) begin
         errors++; $display("FAIL rst_nw got %0d want 0", aes_in_nwords);
      end
      if (s_ready !== 1'b1) begin
         errors++; $display("FAIL rst_sready got %0b want 1", s_ready);
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_basic();
      start();
      ready_mode = 0;
      queue_msg(4, 1, 1, 1, 32'h1);
      send(0, 100);
      checks += 4;
      if (aes_in_valid !== 1'b1) begin
         errors++; $display("FAIL basic_latency valid=%0b want 1", aes_in_valid);
      end
      if (aes_in_block !== 128'h00000001_00000002_00000003_00000004) begin
         errors++; $display("FAIL basic_block got %h", aes_in_block);
      end
      if (aes_in_nwords !== 3'd4) begin
         errors++; $display("FAIL basic_nw got %0d want 4", aes_in_nwords);
      end
      if (aes_in_last !== 1'b1) begin
         errors++; $display("FAIL basic_last got %0b want 1", aes_in_last);
      end
      wait_drain(50);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL basic_blk%0d got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_single();
      start();
      ready_mode = 0;
      queue_msg(1, 1, 1, 1, 32'hDEADBEEF);
      send(0, 100);
      checks += 3;
      if (aes_in_block !== {32'hDEADBEEF, 96'b0}) begin
         errors++; $display("FAIL single_block got %h", aes_in_block);
      end
      if (aes_in_nwords !== 3'd1) begin
         errors++; $display("FAIL single_nw got %0d want 1", aes_in_nwords);
      end
      if (aes_in_last !== 1'b1 || aes_in_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_last got l=%0b v=%0b want 1/1",
                  aes_in_last, aes_in_valid);
      end
      wait_drain(50);
      checks++;
      if (got_q.size() != 1 || got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL single_count got %0d want 1", got_q.size());
      end
   endtask

   task automatic test_backpressure();
      start();
      ready_mode = 2;
      queue_msg(12, 1, 1, 0, 32'h0);
      fork
         begin
            repeat (20) @(posedge clk);
            ready_mode = 0;
         end
         send(0, 300);
      join
      checks++;
      if (first_low != 8) begin
         errors++; $display("FAIL bp_sready_drop got %0d words want 8", first_low);
      end
      wait_drain(100);
      checks += 2;
      if (s_ready !== 1'b1) begin
         errors++; $display("FAIL bp_sready_back got %0b want 1", s_ready);
      end
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL bp_blk%0d got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      start();
      ready_mode = 0;
      queue_msg(16, 0, 1, 0, 32'h0);
      send(0, 100);
      wait_drain(50);
      checks += 2;
      if (low_cnt != 0) begin
         errors++; $display("FAIL b2b_sready_low got %0d cycles want 0", low_cnt);
      end
      if (got_q.size() != 4 || exp_q.size() != 4) begin
         errors++; $display("FAIL b2b_count got %0d want 4", got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_blk%0d got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      for (int i = 1; i < got_cyc.size(); i++) begin
         checks++;
         if (got_cyc[i] - got_cyc[i-1] != 4) begin
            errors++;
            $display("FAIL b2b_spacing%0d got %0d want 4",
                     i, got_cyc[i] - got_cyc[i-1]);
         end
      end
   endtask

   task automatic test_clear();
      start();
      ready_mode = 0;
      queue_msg(2, 0, 0, 0, 32'h0);
      send(0, 50);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      checks++;
      if (aes_in_valid !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_state got v=%0b r=%0b want 0/1",
                  aes_in_valid, s_ready);
      end
      queue_msg(4, 1, 1, 0, 32'h0);
      send(0, 50);
      wait_drain(50);
      checks++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         errors++; $display("FAIL clear_count got %0d want 1", got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL clear_blk got %h want %h", got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      start();
      ready_mode = 2;
      queue_msg(6, 0, 0, 0, 32'h0);
      send(0, 50);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (aes_in_valid !== 1'b0 || aes_in_block !== '0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL arst_async got v=%0b blk=%h r=%0b want 0/0/1",
                  aes_in_valid, aes_in_block, s_ready);
      end
      @(negedge clk);
      #1 rst_n = 1'b1;
      start();
      ready_mode = 0;
      queue_msg(3, 1, 1, 0, 32'h0);
      send(0, 50);
      wait_drain(50);
      checks++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         errors++; $display("FAIL arst_count got %0d want 1", got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL arst_blk got %h want %h", got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      start();
      ready_mode = 1;
      for (int m = 0; m < 8; m++)
         queue_msg(int'($urandom_range(12, 1)), 1, 1, 0, 32'h0);
      send(25, 3000);
      wait_drain(500);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rnd_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rnd_blk%0d got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_clear();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
